// File: rtl/dmem_lsu.sv
// dmem_lsu: load/store unit driving a single-cycle, combinational-read data memory.
// Define LSU_MISALIGNED_EN to split word-crossing accesses into two memory accesses.
module dmem_lsu (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic        i_store,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_store_data,
    output logic        o_resp_valid,
    output logic [31:0] o_load_data,
    output logic        o_err,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_write_data,
    output logic [31:0] o_mem_write_mask,
    output logic        o_mem_write_enable,
    input  logic [31:0] i_mem_read_data
);

    typedef enum logic [1:0] {IDLE = 2'd0, ACC1 = 2'd1, ACC2 = 2'd2, RESP = 2'd3} state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [2:0]  funct3_q, funct3_d;
    logic        store_q, store_d;
    logic [31:0] data_q, data_d;
    logic        err_q, err_d;
    logic        split_q, split_d;
    logic [31:0] lo_q, lo_d;
    logic [23:0] hi_q, hi_d;

    logic        req_legal_s;
    logic        req_cross_s;
    logic [3:0]  st_be_s;
    logic [31:0] st_bmask_s;
    logic [31:0] st_data_lo_s;
    logic [31:0] st_mask_lo_s;
`ifdef LSU_MISALIGNED_EN
    logic [31:0] st_data_hi_s;
    logic [31:0] st_mask_hi_s;
`endif
    logic [55:0] ld_cat_s;
    logic [31:0] ld_word_s;
    logic [31:0] ld_val_s;

    function automatic logic legal_f(input logic store, input logic [2:0] f3);
        case (f3)
            3'b000, 3'b001, 3'b010: legal_f = 1'b1;
            3'b100, 3'b101:         legal_f = ~store;
            default:                legal_f = 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] size_f(input logic [1:0] w);
        case (w)
            2'b00:   size_f = 4'd1;
            2'b01:   size_f = 4'd2;
            default: size_f = 4'd4;
        endcase
    endfunction

    function automatic logic [3:0] be_f(input logic [1:0] w);
        case (w)
            2'b00:   be_f = 4'b0001;
            2'b01:   be_f = 4'b0011;
            default: be_f = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] expand_f(input logic [3:0] be);
        for (int i = 0; i < 4; i++) begin
            expand_f[8*i +: 8] = {8{be[i]}};
        end
    endfunction

    // Request classification at accept time
    always_comb begin
        req_legal_s = legal_f(i_store, i_funct3);
        req_cross_s = ({2'b00, i_addr[1:0]} + size_f(i_funct3[1:0])) > 4'd4;
    end

    // Store data and mask placed into the (up to) two memory words
    always_comb begin
        st_be_s    = be_f(funct3_q[1:0]);
        st_bmask_s = expand_f(st_be_s);
`ifdef LSU_MISALIGNED_EN
        {st_data_hi_s, st_data_lo_s} = {32'd0, data_q & st_bmask_s} << {addr_q[1:0], 3'b000};
        {st_mask_hi_s, st_mask_lo_s} = {32'd0, st_bmask_s} << {addr_q[1:0], 3'b000};
`else
        st_data_lo_s = (data_q & st_bmask_s) << {addr_q[1:0], 3'b000};
        st_mask_lo_s = st_bmask_s << {addr_q[1:0], 3'b000};
`endif
    end

    // Load alignment and sign/zero extension; hi byte 3 can never reach the result
    always_comb begin
        ld_cat_s = {hi_q, lo_q};
        case (addr_q[1:0])
            2'b00:   ld_word_s = ld_cat_s[31:0];
            2'b01:   ld_word_s = ld_cat_s[39:8];
            2'b10:   ld_word_s = ld_cat_s[47:16];
            default: ld_word_s = ld_cat_s[55:24];
        endcase
        case (funct3_q[1:0])
            2'b00:   ld_val_s = funct3_q[2] ? {24'd0, ld_word_s[7:0]}
                                            : {{24{ld_word_s[7]}}, ld_word_s[7:0]};
            2'b01:   ld_val_s = funct3_q[2] ? {16'd0, ld_word_s[15:0]}
                                            : {{16{ld_word_s[15]}}, ld_word_s[15:0]};
            default: ld_val_s = ld_word_s;
        endcase
    end

    // Sequencer next state and memory/response outputs
    always_comb begin
        state_d            = state_q;
        addr_d             = addr_q;
        funct3_d           = funct3_q;
        store_d            = store_q;
        data_d             = data_q;
        err_d              = err_q;
        split_d            = split_q;
        lo_d               = lo_q;
        hi_d               = hi_q;
        o_ready            = 1'b0;
        o_resp_valid       = 1'b0;
        o_load_data        = 32'd0;
        o_err              = 1'b0;
        o_mem_addr         = 32'd0;
        o_mem_write_data   = 32'd0;
        o_mem_write_mask   = 32'd0;
        o_mem_write_enable = 1'b0;
        case (state_q)
            IDLE: begin
                o_ready = 1'b1;
                if (i_valid) begin
                    addr_d   = i_addr;
                    funct3_d = i_funct3;
                    store_d  = i_store;
                    data_d   = i_store_data;
                    lo_d     = 32'd0;
                    hi_d     = 24'd0;
`ifdef LSU_MISALIGNED_EN
                    err_d    = ~req_legal_s;
                    split_d  = req_legal_s & req_cross_s;
`else
                    err_d    = ~req_legal_s | req_cross_s;
                    split_d  = 1'b0;
`endif
                    state_d  = ACC1;
                end else begin
                    state_d  = IDLE;
                end
            end
            ACC1: begin
                o_mem_addr         = {2'b00, addr_q[31:2]};
                o_mem_write_enable = store_q & ~err_q;
                o_mem_write_data   = o_mem_write_enable ? st_data_lo_s : 32'd0;
                o_mem_write_mask   = o_mem_write_enable ? st_mask_lo_s : 32'd0;
                if (!store_q) begin
                    lo_d = i_mem_read_data;
                end else begin
                    lo_d = lo_q;
                end
                state_d = split_q ? ACC2 : RESP;
            end
`ifdef LSU_MISALIGNED_EN
            ACC2: begin
                o_mem_addr         = {2'b00, addr_q[31:2] + 30'd1};
                o_mem_write_enable = store_q & ~err_q;
                o_mem_write_data   = o_mem_write_enable ? st_data_hi_s : 32'd0;
                o_mem_write_mask   = o_mem_write_enable ? st_mask_hi_s : 32'd0;
                if (!store_q) begin
                    hi_d = i_mem_read_data[23:0];
                end else begin
                    hi_d = hi_q;
                end
                state_d = RESP;
            end
`endif
            RESP: begin
                o_resp_valid = 1'b1;
                o_err        = err_q;
                o_load_data  = (err_q | store_q) ? 32'd0 : ld_val_s;
                state_d      = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and request registers
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= IDLE;
            addr_q   <= 32'd0;
            funct3_q <= 3'd0;
            store_q  <= 1'b0;
            data_q   <= 32'd0;
            err_q    <= 1'b0;
            split_q  <= 1'b0;
            lo_q     <= 32'd0;
            hi_q     <= 24'd0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            funct3_q <= funct3_d;
            store_q  <= store_d;
            data_q   <= data_d;
            err_q    <= err_d;
            split_q  <= split_d;
            lo_q     <= lo_d;
            hi_q     <= hi_d;
        end
    end

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed self-checking bench for dmem_lsu with a small behavioural data memory.
module tb_dmem_lsu;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_valid;
    logic        o_ready;
    logic        i_store;
    logic [2:0]  i_funct3;
    logic [31:0] i_addr;
    logic [31:0] i_store_data;
    logic        o_resp_valid;
    logic [31:0] o_load_data;
    logic        o_err;
    logic [31:0] o_mem_addr;
    logic [31:0] o_mem_write_data;
    logic [31:0] o_mem_write_mask;
    logic        o_mem_write_enable;
    logic [31:0] i_mem_read_data;

    logic [31:0] mem [16];
    logic        preload;
    int          cyc = 0;
    int          we_cnt = 0;
    int          checks = 0;
    int          errors = 0;

    int          r_lat;
    int          r_cycle;
    logic [31:0] r_data;
    logic        r_err;
    logic [31:0] tr_addr  [8];
    logic [31:0] tr_wdata [8];
    logic [31:0] tr_mask  [8];
    logic        tr_we    [8];
    int          prev_cycle;
    int          we_before;

    dmem_lsu dut (
        .i_clk              (i_clk),
        .i_rst              (i_rst),
        .i_valid            (i_valid),
        .o_ready            (o_ready),
        .i_store            (i_store),
        .i_funct3           (i_funct3),
        .i_addr             (i_addr),
        .i_store_data       (i_store_data),
        .o_resp_valid       (o_resp_valid),
        .o_load_data        (o_load_data),
        .o_err              (o_err),
        .o_mem_addr         (o_mem_addr),
        .o_mem_write_data   (o_mem_write_data),
        .o_mem_write_mask   (o_mem_write_mask),
        .o_mem_write_enable (o_mem_write_enable),
        .i_mem_read_data    (i_mem_read_data)
    );

    always #5 i_clk = ~i_clk;

    assign i_mem_read_data = mem[o_mem_addr[3:0]];

    always @(posedge i_clk) begin
        cyc <= cyc + 1;
        if (o_mem_write_enable) we_cnt <= we_cnt + 1;
        if (preload) begin
            for (int i = 0; i < 16; i++) mem[i] <= 32'd0;
            mem[4] <= 32'h8899AABB;
            mem[5] <= 32'h11223344;
        end else if (o_mem_write_enable) begin
            mem[o_mem_addr[3:0]] <= (mem[o_mem_addr[3:0]] & ~o_mem_write_mask)
                                  | (o_mem_write_data & o_mem_write_mask);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic preload_mem();
        @(negedge i_clk);
        preload = 1'b1;
        @(negedge i_clk);
        preload = 1'b0;
    endtask

    // Issue one request at a negedge; trace cycles 1..6 after the accept edge
    task automatic do_req(input logic st, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] d, input logic hold);
        @(negedge i_clk);
        chk("ready_before_req", {31'd0, o_ready}, 32'd1);
        i_valid = 1'b1; i_store = st; i_funct3 = f3; i_addr = a; i_store_data = d;
        @(posedge i_clk);
        #1;
        if (!hold) i_valid = 1'b0;
        r_lat = 0; r_data = 32'd0; r_err = 1'b0; r_cycle = 0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge i_clk);
            tr_addr[c]  = o_mem_addr;
            tr_wdata[c] = o_mem_write_data;
            tr_mask[c]  = o_mem_write_mask;
            tr_we[c]    = o_mem_write_enable;
            if (o_resp_valid) begin
                r_lat = c; r_data = o_load_data; r_err = o_err; r_cycle = cyc;
                break;
            end
        end
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        i_rst = 1'b1; i_valid = 1'b0; i_store = 1'b0; i_funct3 = 3'd0;
        i_addr = 32'd0; i_store_data = 32'd0; preload = 1'b1;
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        chk("rst_ready", {31'd0, o_ready}, 32'd1);
        chk("rst_resp",  {31'd0, o_resp_valid}, 32'd0);
        chk("rst_err",   {31'd0, o_err}, 32'd0);
        chk("rst_ldata", o_load_data, 32'd0);
        chk("rst_maddr", o_mem_addr, 32'd0);
        chk("rst_wdata", o_mem_write_data, 32'd0);
        chk("rst_mask",  o_mem_write_mask, 32'd0);
        chk("rst_we",    {31'd0, o_mem_write_enable}, 32'd0);
        i_rst = 1'b0; preload = 1'b0;

        // sign / zero extension
        do_req(1'b0, 3'b000, 32'h13, 32'd0, 1'b0);
        chk("lb_lat", r_lat, 2); chk("lb_data", r_data, 32'hFFFFFF88); chk("lb_err", {31'd0, r_err}, 32'd0);
        chk("lb_addr", tr_addr[1], 32'd4);
        do_req(1'b0, 3'b100, 32'h13, 32'd0, 1'b0);
        chk("lbu_data", r_data, 32'h00000088); chk("lbu_err", {31'd0, r_err}, 32'd0);
        do_req(1'b0, 3'b001, 32'h11, 32'd0, 1'b0);
        chk("lh_off1_lat", r_lat, 2); chk("lh_off1_data", r_data, 32'hFFFF99AA);
        chk("lh_off1_err", {31'd0, r_err}, 32'd0);
        do_req(1'b0, 3'b101, 32'h12, 32'd0, 1'b0);
        chk("lhu_data", r_data, 32'h00008899);

        // split load
        do_req(1'b0, 3'b010, 32'h12, 32'd0, 1'b0);
        chk("lw12_addr1", tr_addr[1], 32'd4);
`ifdef LSU_MISALIGNED_EN
        chk("lw12_addr2", tr_addr[2], 32'd5);
        chk("lw12_lat", r_lat, 3); chk("lw12_data", r_data, 32'h33448899);
        chk("lw12_err", {31'd0, r_err}, 32'd0);
`else
        chk("lw12_lat", r_lat, 2); chk("lw12_data", r_data, 32'd0);
        chk("lw12_err", {31'd0, r_err}, 32'd1);
`endif

        // split store
        we_before = we_cnt;
        do_req(1'b1, 3'b001, 32'h17, 32'h0000BEEF, 1'b0);
        @(negedge i_clk);
`ifdef LSU_MISALIGNED_EN
        chk("sh17_addr1", tr_addr[1], 32'd5);  chk("sh17_wd1", tr_wdata[1], 32'hEF000000);
        chk("sh17_mask1", tr_mask[1], 32'hFF000000); chk("sh17_we1", {31'd0, tr_we[1]}, 32'd1);
        chk("sh17_addr2", tr_addr[2], 32'd6);  chk("sh17_wd2", tr_wdata[2], 32'h000000BE);
        chk("sh17_mask2", tr_mask[2], 32'h000000FF); chk("sh17_we2", {31'd0, tr_we[2]}, 32'd1);
        chk("sh17_lat", r_lat, 3); chk("sh17_err", {31'd0, r_err}, 32'd0);
        chk("sh17_word5", mem[5], 32'hEF223344); chk("sh17_word6", mem[6], 32'h000000BE);
`else
        chk("sh17_lat", r_lat, 2); chk("sh17_err", {31'd0, r_err}, 32'd1);
        chk("sh17_we_cnt", we_cnt - we_before, 0);
        chk("sh17_word5", mem[5], 32'h11223344);
`endif
        chk("sh17_ldata", r_data, 32'd0);

        // illegal funct3
        preload_mem();
        we_before = we_cnt;
        do_req(1'b0, 3'b011, 32'h10, 32'd0, 1'b0);
        chk("ill_ld_err", {31'd0, r_err}, 32'd1); chk("ill_ld_data", r_data, 32'd0);
        chk("ill_ld_lat", r_lat, 2);
        do_req(1'b1, 3'b100, 32'h10, 32'h12345678, 1'b0);
        @(negedge i_clk);
        chk("ill_st_err", {31'd0, r_err}, 32'd1);
        chk("ill_we_cnt", we_cnt - we_before, 0);
        chk("ill_word4", mem[4], 32'h8899AABB);

        // reset during ACC1 of a split store
        @(negedge i_clk);
        i_valid = 1'b1; i_store = 1'b1; i_funct3 = 3'b001; i_addr = 32'h17; i_store_data = 32'h0000BEEF;
        @(posedge i_clk);
        #1 i_valid = 1'b0;
        @(negedge i_clk);
`ifdef LSU_MISALIGNED_EN
        chk("rst_mid_we_before", {31'd0, o_mem_write_enable}, 32'd1);
`else
        chk("rst_mid_we_before", {31'd0, o_mem_write_enable}, 32'd0);
`endif
        #1 i_rst = 1'b1;
        #1;
        chk("rst_mid_we_drop", {31'd0, o_mem_write_enable}, 32'd0);
        chk("rst_mid_resp", {31'd0, o_resp_valid}, 32'd0);
        @(posedge i_clk);
        @(negedge i_clk);
        i_rst = 1'b0;
        chk("rst_mid_ready", {31'd0, o_ready}, 32'd1);
        for (int k = 0; k < 3; k++) begin
            @(negedge i_clk);
            chk("rst_mid_no_resp", {31'd0, o_resp_valid}, 32'd0);
        end
        chk("rst_mid_word5", mem[5], 32'h11223344);
        chk("rst_mid_word6", mem[6], 32'd0);
        do_req(1'b0, 3'b010, 32'h10, 32'd0, 1'b0);
        chk("rst_mid_lw10", r_data, 32'h8899AABB);

        // back-to-back with i_valid held high
        do_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 1'b1);
        chk("b2b_sw_lat", r_lat, 2);
        prev_cycle = r_cycle;
        for (int k = 0; k < 3; k++) begin
            if (k % 2 == 0) begin
                do_req(1'b0, 3'b010, 32'h10, 32'd0, 1'b1);
                chk("b2b_lw_data", r_data, 32'hDEADBEEF);
            end else begin
                do_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 1'b1);
                chk("b2b_sw_data", r_data, 32'd0);
            end
            chk("b2b_spacing", r_cycle - prev_cycle, 3);
            prev_cycle = r_cycle;
        end
        i_valid = 1'b0;
        @(negedge i_clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
